// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// reset PC, bubble value and the PC increment helper.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Wraps modulo 2^32; the low two address bits are carried through unchecked.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry skid register holding a word fetched while ID was frozen,
// together with its fetch address + 4.
module if_skid_buf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    // Clear wins over load so a redirect always discards the parked word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (FETCH/HOLD/DRAIN) and IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        valid_q;

    logic        xfer;
    logic [31:0] pc_inc;
    logic        skid_load;
    logic        skid_clear;
    logic        deliver;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_valid;

    // DRAIN keeps presenting the abandoned address until memory acks it.
    always_comb begin
        imem_req   = rst && (state_q != ST_HOLD);
        imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
        xfer       = imem_req && imem_ack;
        pc_inc     = next_pc(pc_q);
        skid_load  = (state_q == ST_FETCH) && xfer && freeze && !branch_taken;
        skid_clear = branch_taken || ((state_q == ST_HOLD) && !freeze);
        deliver    = !branch_taken &&
                     (((state_q == ST_FETCH) && xfer && !freeze) ||
                      ((state_q == ST_HOLD) && !freeze));
    end

    if_skid_buf u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (pc_inc),
        .instr_o (skid_instr),
        .pc_o    (skid_pc),
        .valid_o (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= BUBBLE;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (branch_taken) begin
                        pc_q    <= branch_addr;
                        instr_q <= BUBBLE;
                        valid_q <= 1'b0;
                        if (!xfer) begin
                            state_q      <= ST_DRAIN;
                            drain_addr_q <= pc_q;
                        end
                    end else if (xfer) begin
                        pc_q <= pc_inc;
                        if (freeze) begin
                            state_q <= ST_HOLD;
                        end else begin
                            instr_q  <= imem_rdata;
                            pc_out_q <= pc_inc;
                            valid_q  <= 1'b1;
                        end
                    end else if (!freeze) begin
                        instr_q <= BUBBLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        pc_q    <= branch_addr;
                        instr_q <= BUBBLE;
                        valid_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end else if (!freeze) begin
                        instr_q  <= skid_instr;
                        pc_out_q <= skid_pc;
                        valid_q  <= skid_valid;
                        state_q  <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Returned data belongs to the abandoned path and is dropped.
                    if (branch_taken) begin
                        pc_q    <= branch_addr;
                        instr_q <= BUBBLE;
                        valid_q <= 1'b0;
                    end
                    if (xfer) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid_out   = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            if (deliver) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (freeze) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port freeze, input, 1, hazard from ID; hold IF/ID outputs when high.
REQ-004 SHALL have port branch_taken, input, 1, redirect/flush request from EXE.
REQ-005 SHALL have port branch_addr, input, 32, redirect target, byte address.
REQ-006 SHALL have port imem_req, output, 1, instruction memory request.
REQ-007 SHALL have port imem_addr, output, 32, fetch address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1, memory completes the transfer this cycle.
REQ-009 SHALL have port imem_rdata, input, 32, fetched word, valid with imem_ack.
REQ-010 SHALL have port instruction, output, 32, IF/ID instruction register.
REQ-011 SHALL have port pc_out, output, 32, IF/ID register holding fetch address + 4.
REQ-012 SHALL have port valid_out, output, 1, IF/ID register holds a real instruction.

Function
REQ-013 SHALL implement states FETCH, HOLD and DRAIN; a transfer completes on a rising edge with imem_req and imem_ack both high.
REQ-014 SHALL drive imem_req combinationally high in FETCH and DRAIN, and low in HOLD and while rst is low.
REQ-015 SHALL keep imem_addr stable from imem_req assertion until the transfer completes.
REQ-016 FETCH, transfer completes, freeze low: instruction<=imem_rdata, pc_out<=pc+4, valid_out<=1, pc<=pc+4; stay in FETCH.
REQ-017 FETCH, transfer completes, freeze high: imem_rdata and pc+4 go to the skid sub-module, pc<=pc+4, IF/ID outputs unchanged, next state HOLD.
REQ-018 FETCH, no transfer, freeze low: valid_out<=0 and instruction<=0 (bubble); pc unchanged.
REQ-019 FETCH, no transfer, freeze high: all IF/ID outputs and pc unchanged.
REQ-020 HOLD, freeze high: all outputs unchanged; HOLD, freeze low: IF/ID<=skid contents, valid_out<=1, next state FETCH.
REQ-021 branch_taken SHALL override freeze in every state: pc<=branch_addr, valid_out<=0, instruction<=0, skid discarded.
REQ-022 branch_taken in FETCH with a request outstanding and no ack that cycle SHALL go to DRAIN; any other branch case SHALL go to FETCH.
REQ-023 DRAIN SHALL keep the old address until ack, discard the returned data, then go to FETCH at the new pc; a further branch in DRAIN updates pc and stays in DRAIN.
REQ-024 pc arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0x00000000); pc[1:0] are not checked.
REQ-025 Latency: a word acked with freeze low SHALL appear on instruction/valid_out on the next cycle.

Reset
REQ-026 While rst is low at a clock edge, the block SHALL set pc=RESET_PC (0), instruction=0, pc_out=0, valid_out=0, skid cleared, state FETCH.
REQ-027 Reset mid-transfer SHALL abandon the request (imem_req low during reset); the first request after reset SHALL use address 0.

Configuration
REQ-028 With IF_PERF_CNT_EN defined, the block SHALL add outputs fetch_count[31:0] (increments on each transfer delivered to IF/ID) and stall_count[31:0] (increments each cycle freeze is high); both wrap, reset to 0, and branch does not clear them.
REQ-029 Without IF_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 The shared defines file SHALL hold the state encodings, RESET_PC and the bubble value (32'h0).
REQ-031 The skid storage SHALL be one sub-module, if_skid_buf (32-bit instruction, 32-bit pc, valid bit, load/clear), and the PC/FSM SHALL stay in if_stage.

Verification
REQ-032 Reset then ack every cycle with rdata=0xE0000000+n -> valid_out=1 from the 2nd cycle, pc_out 4, 8, 12...
REQ-033 Ack with rdata=0x11111111 while freeze=1 for 3 cycles -> imem_req low in HOLD, outputs frozen; on release instruction=0x11111111 next cycle.
REQ-034 Request at 0x40 outstanding, branch_taken with branch_addr=0x100, ack 2 cycles later -> data discarded, valid_out=0, next imem_addr=0x100.
REQ-035 Branch while freeze=1 and in HOLD -> skid discarded, valid_out=0, fetch resumes at branch_addr.
REQ-036 Branch to 0xFFFFFFFC, ack -> pc_out=0x00000000, next imem_addr=0.
REQ-037 rst low mid-request, then high -> imem_req=0 during reset and the first address is 0; with IF_PERF_CNT_EN, counters = 0.
